trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequencer for machine-mode traps and `mret` in the core.
- Arbitrates between synchronous exceptions, pending interrupts and `mret`.
- Flushes the pipeline, then drives the CSR file's exception write port (`we_exc`, `mcause`, `mepc`, `mtval`, `mstatus`) for one cycle, then redirects the PC.
- Sits between the decode/execute stages, the CSR file and the fetch unit.

Parameters:
- FLUSH_TIMEOUT, 16: maximum cycles to wait for `flush_ack_i`. On expiry the FSM proceeds and pulses `flush_timeout_o`. Legal range is 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- exc_valid_i  in  1  synchronous exception from execute
- exc_cause_i  in  4  exception code
- exc_pc_i  in  32  PC of faulting instruction
- exc_tval_i  in  32  trap value
- mret_i  in  1  `mret` retiring
- irq_ext_i / irq_sw_i / irq_timer_i  in  1 each  interrupt pending lines
- cur_pc_i  in  32  PC of next instruction to execute (epc for interrupts)
- mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i  in  32 each  current CSR values
- flush_ack_i  in  1  pipeline drained
- flush_o  out  1  pipeline flush request
- we_exc_o  out  1  CSR exception write strobe
- mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o  out  32 each  CSR write data
- pc_redirect_o  out  1  fetch redirect strobe
- pc_target_o  out  32  redirect target
- busy_o  out  1  FSM not IDLE
- flush_timeout_o  out  1  one-cycle pulse on flush timeout

Behaviour:
- Reset (`rst_i`=0, async):
  - FSM goes to IDLE; all outputs and captured registers are 0.
  - Reset mid-sequence aborts with no CSR write and no redirect.
- States: IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE.
- IDLE: evaluate events each cycle. Priority is exception > `mret` > interrupt.
- Interrupt eligibility: taken only if `mstatus_i[3]` (MIE)=1 and the matching enable bit is 1 (`mie_i[11]`, `mie_i[3]`, `mie_i[7]`).
- Interrupt priority among eligible sources: ext (cause 11) > sw (cause 3) > timer (cause 7).
- On an accepted event, capture in one cycle: kind, cause, epc, tval, and `mstatus_i`/`mtvec_i`/`mepc_i`/`mcause_i`. Then go to FLUSH with `flush_o`=1.
- FLUSH:
  - `flush_o` stays high until `flush_ack_i`=1 sampled, then go to WRITE.
  - A counter starts at 0 on entry. If it reaches FLUSH_TIMEOUT without ack: pulse `flush_timeout_o` for 1 cycle and go to WRITE.
  - Ack and expiry in the same cycle: the ack wins, no timeout pulse.
- WRITE: `we_exc_o`=1 for exactly one cycle.
  - Trap:
    - `mepc_d_o` = epc with bits[1:0] cleared.
    - `mcause_d_o` = {is_irq, 27'b0, cause}.
    - `mtval_d_o` = tval (0 for interrupts).
    - `mstatus_d_o` = captured mstatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - `mret`:
    - `mepc_d_o` = captured mepc.
    - `mcause_d_o` = captured mcause.
    - `mtval_d_o` = 0.
    - `mstatus_d_o` = captured mstatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11.
- REDIRECT: `pc_redirect_o`=1 for one cycle.
  - Trap: `pc_target_o` = {`mtvec`[31:2], 2'b00}.
  - `mret`: `pc_target_o` = captured mepc.
- Outputs outside their active state:
  - `we_exc_o` and `pc_redirect_o` are 0.
  - Data outputs hold their last value.
- `busy_o` = 1 in every state except IDLE.
- Events arriving while `busy_o`=1 are ignored. Upstream stalls until `busy_o` falls; a still-pending interrupt is re-evaluated in IDLE.
- Total latency from event to redirect: 3 cycles plus the flush wait.

Optional Feature:
- TRAP_VECTORED_EN, defined: for an interrupt trap with `mtvec[1:0]`=2'b01, `pc_target_o` = {`mtvec`[31:2],2'b00} + 4*cause. Exceptions and other modes use the base.
- Undefined: mode bits ignored; always base.

Test Plan:
- `exc_valid_i`=1, cause=2, `exc_pc_i`=0x104, `mtvec_i`=0x200, `mstatus_i`=0x8, ack after 2 cycles -> one `we_exc_o` pulse with `mepc_d_o`=0x104, `mcause_d_o`=0x2, `mstatus_d_o`=0x1880; then `pc_redirect_o`, target 0x200.
- `irq_timer_i`=1, `mie_i[7]`=1, MIE=1, `cur_pc_i`=0x300 -> `mcause_d_o`=0x80000007, `mepc_d_o`=0x300, `mtval_d_o`=0. Same stimulus with MIE=0 -> no sequence, `busy_o` stays 0.
- `irq_ext_i`, `irq_sw_i`, `irq_timer_i` and `exc_valid_i` (cause 4) all in the same cycle -> exception taken, `mcause_d_o`=0x4. Next trap with only the three irqs -> cause 0x8000000B.
- `mret_i`=1, `mstatus_i`=0x80, `mepc_i`=0x400 -> `mstatus_d_o`=0x1888, target 0x400.
- `flush_ack_i` never asserted, FLUSH_TIMEOUT=4 -> `flush_timeout_o` pulses after 4 FLUSH cycles, then WRITE proceeds. `rst_i` low during WRITE -> `we_exc_o`=0 immediately, state IDLE, no redirect.
- TRAP_VECTORED_EN defined, `mtvec_i`=0x201, `irq_ext_i` -> target 0x22C. Undefined -> target 0x200.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap / mret sequencer: IDLE -> FLUSH -> WRITE -> REDIRECT.
// Define TRAP_VECTORED_EN to vector interrupts through mtvec mode 2'b01.
module trap_ctrl #(
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic [31:0] cur_pc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic        flush_ack_i,
    output logic        flush_o,
    output logic        we_exc_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mtval_d_o,
    output logic [31:0] mstatus_d_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_target_o,
    output logic        busy_o,
    output logic        flush_timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WRITE, S_REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_d;

    logic        is_irq_q, is_mret_q;
    logic [3:0]  cause_q;
    logic [31:0] epc_q, tval_q, mstatus_q, mtvec_q, mepc_q, mcause_q;

    logic [31:0] mcause_o_q, mepc_o_q, mtval_o_q, mstatus_o_q, target_o_q, timeout_o_q;

    logic        ext_ok, sw_ok, tmr_ok, irq_any, accept;
    logic [3:0]  irq_cause;

    assign ext_ok  = mstatus_i[3] & mie_i[11] & irq_ext_i;
    assign sw_ok   = mstatus_i[3] & mie_i[3]  & irq_sw_i;
    assign tmr_ok  = mstatus_i[3] & mie_i[7]  & irq_timer_i;
    assign irq_any = ext_ok | sw_ok | tmr_ok;
    assign accept  = exc_valid_i | mret_i | irq_any;

    always_comb begin
        irq_cause = 4'd7;
        if (ext_ok)     irq_cause = 4'd11;
        else if (sw_ok) irq_cause = 4'd3;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH: begin
                // An ack in the expiry cycle still counts as a clean drain.
                if (flush_ack_i) begin
                    state_d = S_WRITE;
                end else if (cnt_q == 8'(FLUSH_TIMEOUT - 1)) begin
                    state_d   = S_WRITE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE:    state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // CSR write data computed from the captured snapshot.
    logic [31:0] wr_mcause, wr_mepc, wr_mtval, wr_mstatus, wr_target, trap_base;

    assign trap_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        wr_mstatus = mstatus_q;
        wr_mcause  = {is_irq_q, 27'b0, cause_q};
        wr_mepc    = {epc_q[31:2], 2'b00};
        wr_mtval   = is_irq_q ? 32'd0 : tval_q;
        wr_target  = trap_base;
        if (is_mret_q) begin
            wr_mstatus[3]     = mstatus_q[7];
            wr_mstatus[7]     = 1'b1;
            wr_mstatus[12:11] = 2'b11;
            wr_mcause         = mcause_q;
            wr_mepc           = mepc_q;
            wr_mtval          = 32'd0;
            wr_target         = mepc_q;
        end else begin
            wr_mstatus[7]     = mstatus_q[3];
            wr_mstatus[3]     = 1'b0;
            wr_mstatus[12:11] = 2'b11;
`ifdef TRAP_VECTORED_EN
            if (is_irq_q && mtvec_q[1:0] == 2'b01)
                wr_target = trap_base + {26'd0, cause_q, 2'b00};
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_irq_q    <= 1'b0;
            is_mret_q   <= 1'b0;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
            mstatus_q   <= '0;
            mtvec_q     <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mcause_o_q  <= '0;
            mepc_o_q    <= '0;
            mtval_o_q   <= '0;
            mstatus_o_q <= '0;
            target_o_q  <= '0;
            timeout_o_q <= '0;
        end else begin
            timeout_o_q <= {31'd0, timeout_d};
            if (state_q == S_IDLE && accept) begin
                is_irq_q  <= ~exc_valid_i & ~mret_i;
                is_mret_q <= ~exc_valid_i & mret_i;
                cause_q   <= exc_valid_i ? exc_cause_i : irq_cause;
                epc_q     <= exc_valid_i ? exc_pc_i : cur_pc_i;
                tval_q    <= exc_valid_i ? exc_tval_i : 32'd0;
                mstatus_q <= mstatus_i;
                mtvec_q   <= mtvec_i;
                mepc_q    <= mepc_i;
                mcause_q  <= mcause_i;
            end
            // Data outputs are loaded on entry to their active state and held afterwards.
            if (state_q == S_FLUSH && state_d == S_WRITE) begin
                mcause_o_q  <= wr_mcause;
                mepc_o_q    <= wr_mepc;
                mtval_o_q   <= wr_mtval;
                mstatus_o_q <= wr_mstatus;
            end
            if (state_q == S_WRITE)
                target_o_q <= wr_target;
        end
    end

    assign flush_o         = (state_q == S_FLUSH);
    assign we_exc_o        = (state_q == S_WRITE);
    assign pc_redirect_o   = (state_q == S_REDIRECT);
    assign busy_o          = (state_q != S_IDLE);
    assign flush_timeout_o = timeout_o_q[0];
    assign mcause_d_o      = mcause_o_q;
    assign mepc_d_o        = mepc_o_q;
    assign mtval_d_o       = mtval_o_q;
    assign mstatus_d_o     = mstatus_o_q;
    assign pc_target_o     = target_o_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl (FLUSH_TIMEOUT=4); expected values are hand-computed.
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exc_valid_i, mret_i, irq_ext_i, irq_sw_i, irq_timer_i, flush_ack_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, cur_pc_i, mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i;
    logic        flush_o, we_exc_o, pc_redirect_o, busy_o, flush_timeout_o;
    logic [31:0] mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, pc_target_o;

    int n_vec = 0;
    int n_err = 0;

    trap_ctrl #(.FLUSH_TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .cur_pc_i(cur_pc_i), .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i),
        .mepc_i(mepc_i), .mcause_i(mcause_i), .flush_ack_i(flush_ack_i),
        .flush_o(flush_o), .we_exc_o(we_exc_o),
        .mcause_d_o(mcause_d_o), .mepc_d_o(mepc_d_o), .mtval_d_o(mtval_d_o),
        .mstatus_d_o(mstatus_d_o), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
        .busy_o(busy_o), .flush_timeout_o(flush_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        {exc_valid_i, mret_i, irq_ext_i, irq_sw_i, irq_timer_i, flush_ack_i} = '0;
        exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0; cur_pc_i = '0;
        mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0; mcause_i = '0;
        repeat (3) tick;
        check("rst_busy", busy_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_we", we_exc_o, 0);
        check("rst_redirect", pc_redirect_o, 0);
        check("rst_mepc", mepc_d_o, 0);
        check("rst_target", pc_target_o, 0);
        rst_i = 1'b1;

        // Exception cause 2, ack after two FLUSH cycles.
        tick;
        exc_valid_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h104; exc_tval_i = 32'h55;
        mtvec_i = 32'h200; mstatus_i = 32'h8;
        tick; exc_valid_i = 0;
        check("t1_flush0", flush_o, 1);
        check("t1_busy", busy_o, 1);
        tick; flush_ack_i = 1;
        check("t1_flush1", flush_o, 1);
        tick; flush_ack_i = 0;
        check("t1_we", we_exc_o, 1);
        check("t1_flush_off", flush_o, 0);
        check("t1_mepc", mepc_d_o, 32'h104);
        check("t1_mcause", mcause_d_o, 32'h2);
        check("t1_mstatus", mstatus_d_o, 32'h1880);
        check("t1_mtval", mtval_d_o, 32'h55);
        tick;
        check("t1_we_once", we_exc_o, 0);
        check("t1_redirect", pc_redirect_o, 1);
        check("t1_target", pc_target_o, 32'h200);
        tick;
        check("t1_idle", busy_o, 0);
        check("t1_redirect_once", pc_redirect_o, 0);
        check("t1_mepc_hold", mepc_d_o, 32'h104);

        // Timer interrupt, immediate ack.
        irq_timer_i = 1; mie_i = 32'h80; cur_pc_i = 32'h300;
        tick; irq_timer_i = 0; flush_ack_i = 1;
        check("t2_flush", flush_o, 1);
        tick; flush_ack_i = 0;
        check("t2_we", we_exc_o, 1);
        check("t2_mcause", mcause_d_o, 32'h8000_0007);
        check("t2_mepc", mepc_d_o, 32'h300);
        check("t2_mtval", mtval_d_o, 32'h0);
        tick;
        check("t2_target", pc_target_o, 32'h200);
        tick;

        // Same interrupt with global MIE clear is never taken.
        mstatus_i = 32'h0; irq_timer_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t2_masked_busy", busy_o, 0);
        end
        irq_timer_i = 0; mstatus_i = 32'h8;

        // Exception beats all three interrupts; irqs held pending are taken afterwards.
        mie_i = 32'h888; exc_valid_i = 1; exc_cause_i = 4'd4; exc_pc_i = 32'h10B;
        exc_tval_i = 32'h77; irq_ext_i = 1; irq_sw_i = 1; irq_timer_i = 1;
        tick; exc_valid_i = 0; flush_ack_i = 1;
        tick; flush_ack_i = 0;
        check("t3_we", we_exc_o, 1);
        check("t3_mcause", mcause_d_o, 32'h4);
        check("t3_mepc_align", mepc_d_o, 32'h108);
        tick; cur_pc_i = 32'h500;
        check("t3_redirect", pc_redirect_o, 1);
        tick;
        check("t3_idle_gap", busy_o, 0);
        tick; flush_ack_i = 1;
        check("t3_irq_flush", flush_o, 1);
        tick; flush_ack_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
        check("t3_irq_we", we_exc_o, 1);
        check("t3_irq_mcause", mcause_d_o, 32'h8000_000B);
        check("t3_irq_mepc", mepc_d_o, 32'h500);
        check("t3_irq_mtval", mtval_d_o, 32'h0);
        tick;
        check("t3_irq_target", pc_target_o, 32'h200);
        tick;

        // mret restores MIE from MPIE and returns to mepc.
        mret_i = 1; mstatus_i = 32'h80; mepc_i = 32'h400; mcause_i = 32'h1234_0003;
        tick; mret_i = 0; flush_ack_i = 1;
        tick; flush_ack_i = 0;
        check("t4_we", we_exc_o, 1);
        check("t4_mstatus", mstatus_d_o, 32'h1888);
        check("t4_mepc", mepc_d_o, 32'h400);
        check("t4_mcause", mcause_d_o, 32'h1234_0003);
        check("t4_mtval", mtval_d_o, 32'h0);
        tick;
        check("t4_target", pc_target_o, 32'h400);
        tick;

        // Flush timeout, then reset during WRITE.
        mstatus_i = 32'h8; exc_valid_i = 1; exc_cause_i = 4'd1; exc_pc_i = 32'h600;
        tick; exc_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            check("t5_flush_wait", flush_o, 1);
            check("t5_no_early_to", flush_timeout_o, 0);
            tick;
        end
        check("t5_timeout", flush_timeout_o, 1);
        check("t5_we", we_exc_o, 1);
        check("t5_mepc", mepc_d_o, 32'h600);
        #1 rst_i = 0;
        #1;
        check("t5_rst_we", we_exc_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_mepc", mepc_d_o, 0);
        tick;
        check("t5_rst_redirect", pc_redirect_o, 0);
        rst_i = 1;
        tick;
        check("t5_post_redirect", pc_redirect_o, 0);

        // Ack in the expiry cycle: no timeout pulse.
        exc_valid_i = 1; exc_cause_i = 4'd5; exc_pc_i = 32'h700;
        tick; exc_valid_i = 0;
        repeat (3) tick;
        flush_ack_i = 1;
        check("t6_flush_last", flush_o, 1);
        tick; flush_ack_i = 0;
        check("t6_we", we_exc_o, 1);
        check("t6_no_timeout", flush_timeout_o, 0);
        tick;
        check("t6_redirect", pc_redirect_o, 1);
        tick;

        // External interrupt with mtvec mode 2'b01.
        mtvec_i = 32'h201; mie_i = 32'h800; irq_ext_i = 1;
        tick; irq_ext_i = 0; flush_ack_i = 1;
        tick; flush_ack_i = 0;
        check("t7_mcause", mcause_d_o, 32'h8000_000B);
        tick;
`ifdef TRAP_VECTORED_EN
        check("t7_target", pc_target_o, 32'h22C);
`else
        check("t7_target", pc_target_o, 32'h200);
`endif
        tick;

        // Exceptions always use the base, even in vectored mode.
        exc_valid_i = 1; exc_cause_i = 4'd3; exc_pc_i = 32'h800;
        tick; exc_valid_i = 0; flush_ack_i = 1;
        tick; flush_ack_i = 0;
        tick;
        check("t8_exc_target", pc_target_o, 32'h200);
        tick;
        check("t8_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
